// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with programmable almost-full/empty
// thresholds, exact occupancy, synchronous flush and a high-water-mark monitor.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic                         wr_en,
  output logic                         rd_en,
  input  logic                         flush,
  input  logic [$clog2(DEPTH):0]       af_thresh,
  input  logic [$clog2(DEPTH):0]       ae_thresh,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       hwm,
  input  logic                         hwm_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      hwm_q, hwm_d;

  // Ready never looks at out_ready, so no ready-to-ready combinational path.
  assign in_ready     = !flush && (count_q != FULL_CNT);
  assign out_valid    = !flush && (count_q != '0);
  assign wr_en        = in_valid && in_ready;
  assign rd_en        = out_valid && out_ready;
  assign out_data     = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign hwm          = hwm_q;
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
      else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
    end
  end

  // Peak tracks the post-edge occupancy; a clear restarts it from there.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr)               hwm_d = count_d;
    else if (count_d > hwm_q)  hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: directed scenarios plus a randomized run against a queue model.
module tb_stream_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic             wr_en, rd_en, flush, almost_full, almost_empty, hwm_clr;
  logic [AW:0]      af_thresh, ae_thresh, count, hwm;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  int               mhwm = 0;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .hwm(hwm), .hwm_clr(hwm_clr)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model applies the queue semantics to the current inputs.
  task automatic tick();
    bit w, r;
    w = in_valid && !flush && (mq.size() < DEPTH);
    r = out_ready && !flush && (mq.size() > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (r) void'(mq.pop_front());
      if (w) mq.push_back(in_data);
    end
    if (hwm_clr) mhwm = mq.size();
    else if (mq.size() > mhwm) mhwm = mq.size();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; hwm_clr = 0; in_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    af_thresh = 0; ae_thresh = 2;
    rst_n = 0;
    mq.delete(); mhwm = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", wr_en, rd_en); end
    checks++; if (count !== 5'd0 || hwm !== 5'd0) begin failures++; $display("FAIL reset_count_hwm got=%0d/%0d exp=0/0", count, hwm); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL reset_af_zero got=%b exp=1", almost_full); end
    af_thresh = 14; #1;
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af14 got=%b exp=0", almost_full); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL post_reset got count=%0d ov=%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_fill();
    af_thresh = 14; out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = WIDTH'(i); #1;
      checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL fill_wr_en i=%0d got=%b exp=1", i, wr_en); end
      tick();
      checks++; if (count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_af got=%b exp=1", almost_full); end
    checks++; if (hwm !== 5'd16) begin failures++; $display("FAIL fill_hwm got=%0d exp=16", hwm); end
    in_data = 8'hAA; #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL fill_overflow_wr_en got=%b exp=0", wr_en); end
    tick();
    in_valid = 0;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_overflow_count got=%0d exp=16", count); end
  endtask

  task automatic test_drain();
    ae_thresh = 2; out_ready = 1; in_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, WIDTH'(i)); end
      checks++; if (almost_empty !== (mq.size() <= 2)) begin failures++; $display("FAIL drain_ae size=%0d got=%b", mq.size(), almost_empty); end
      tick();
    end
    out_ready = 0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, out_valid); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL drain_ae_end got=%b exp=1", almost_empty); end
    checks++; if (hwm !== 5'd16) begin failures++; $display("FAIL drain_hwm got=%0d exp=16", hwm); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = WIDTH'($urandom); tick();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL b2b_full got=%0d exp=16", count); end
    in_valid = 1; out_ready = 1; in_data = 8'h77; #1;
    checks++; if (wr_en !== 1'b0 || rd_en !== 1'b1) begin failures++; $display("FAIL b2b_full_strobes got=%b%b exp=01", wr_en, rd_en); end
    tick();
    checks++; if (count !== 5'd15 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_after_full got=%0d/%b exp=15/1", count, in_ready); end
    for (int i = 0; i < 40; i++) begin
      in_data = WIDTH'($urandom); #1;
      checks++; if (out_data !== mq[0] || wr_en !== 1'b1 || rd_en !== 1'b1) begin failures++; $display("FAIL b2b_wrap i=%0d got=%h %b%b exp=%h 11", i, out_data, wr_en, rd_en, mq[0]); end
      tick();
      checks++; if (count !== 5'd15) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=15", i, count); end
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_flush();
    int hexp;
    out_ready = 1; in_valid = 0;
    while (mq.size() > 5) tick();
    out_ready = 0;
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    hexp = mhwm;
    flush = 1; in_valid = 1; in_data = 8'h55; #1;
    checks++; if (wr_en !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL flush_forced got=%b%b%b%b exp=0000", wr_en, in_ready, out_valid, rd_en); end
    tick();
    flush = 0; in_valid = 0;
    checks++; if (count !== 5'd0 || hwm !== 5'(hexp)) begin failures++; $display("FAIL flush_after got=%0d/%0d exp=0/%0d", count, hwm, hexp); end
    in_valid = 1; in_data = 8'h3C; tick(); in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin failures++; $display("FAIL flush_next_head got=%b/%h exp=1/3c", out_valid, out_data); end
  endtask

  task automatic test_hwm_clr();
    hwm_clr = 1; tick(); hwm_clr = 0;
    checks++; if (hwm !== 5'd1) begin failures++; $display("FAIL hwmclr_reload got=%0d exp=1", hwm); end
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin in_data = WIDTH'(i); tick(); end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 0;
    checks++; if (count !== 5'd3 || hwm !== 5'd9) begin failures++; $display("FAIL hwmclr_pre got=%0d/%0d exp=3/9", count, hwm); end
    hwm_clr = 1; tick(); hwm_clr = 0;
    checks++; if (hwm !== 5'd3) begin failures++; $display("FAIL hwmclr_pulse got=%0d exp=3", hwm); end
    in_valid = 1; in_data = 8'h99; tick(); in_valid = 0;
    checks++; if (hwm !== 5'd4) begin failures++; $display("FAIL hwmclr_grow got=%0d exp=4", hwm); end
  endtask

  task automatic test_random();
    bit ir, ov;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) begin
        in_valid = 1; out_ready = 1;
        #2 rst_n = 0;
        mq.delete(); mhwm = 0;
        #1;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || hwm !== 5'd0) begin failures++; $display("FAIL rand_reset got=%0d/%b/%0d exp=0/0/0", count, out_valid, hwm); end
        @(negedge clk);
        rst_n = 1;
      end
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      flush     = ($urandom_range(99) == 0);
      hwm_clr   = ($urandom_range(49) == 0);
      in_data   = WIDTH'($urandom);
      af_thresh = 5'($urandom);
      ae_thresh = 5'($urandom);
      #1;
      ir = !flush && (mq.size() != DEPTH);
      ov = !flush && (mq.size() != 0);
      checks++; if (count !== 5'(mq.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
      checks++; if (in_ready !== ir || out_valid !== ov) begin failures++; $display("FAIL rand_ready_valid cyc=%0d got=%b%b exp=%b%b", cyc, in_ready, out_valid, ir, ov); end
      checks++; if (wr_en !== (in_valid && ir) || rd_en !== (out_ready && ov)) begin failures++; $display("FAIL rand_strobes cyc=%0d got=%b%b", cyc, wr_en, rd_en); end
      if (ov) begin
        checks++; if (out_data !== mq[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]); end
      end
      checks++; if (almost_full !== (mq.size() >= int'(af_thresh)) || almost_empty !== (mq.size() <= int'(ae_thresh))) begin failures++; $display("FAIL rand_thresh cyc=%0d got af=%b ae=%b size=%0d", cyc, almost_full, almost_empty, mq.size()); end
      checks++; if (hwm !== 5'(mhwm)) begin failures++; $display("FAIL rand_hwm cyc=%0d got=%0d exp=%0d", cyc, hwm, mhwm); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_hwm_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
